// File: rtl/cmp_pkg.sv
// cmp_pkg: shared types for the chunk-serial comparator.
//   state_t  - controller states (IDLE, RUN, DONE)
//   RES_*    - one-hot result encoding, bit order {LT, GT, EQ}.
//              RES_NONE is the all-zero post-reset value.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b001;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b100;

endpackage

// File: rtl/cmp_chunk.sv
// cmp_chunk: combinational unsigned magnitude compare of two W-bit slices.
//   a, b : slice inputs
//   eq   : a == b
//   gt   : a >  b (unsigned)
module cmp_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/cmp_seq.sv
// cmp_seq: chunk-serial magnitude comparator for LEN-bit operands.
// The sign-extension bits are compared at accept time; if they agree the
// operands are walked CHUNK bits per cycle from the MSB, stopping at the
// first differing slice.
//   clk, rst             - clock, async active-high reset
//   in_valid / in_ready  - operand handshake (accepted only in IDLE)
//   A, B                 - operands
//   A_SIGNED, B_SIGNED   - per-operand two's-complement select
//   out_valid/out_ready  - result handshake (held in DONE until taken)
//   EQ, GT, LT           - one-hot result
//   CNT                  - chunks examined before the decision
module cmp_seq
  import cmp_pkg::*;
#(
  parameter  int LEN    = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = LEN / CHUNK,
  localparam int CW     = $clog2(NCHUNK + 1),
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] A,
  input  logic [LEN-1:0] B,
  input  logic           A_SIGNED,
  input  logic           B_SIGNED,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           EQ,
  output logic           GT,
  output logic           LT,
  output logic [CW-1:0]  CNT
);

  state_t         state_q, state_d;
  logic [LEN-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     res_q, res_d;

  // Extension bits: each operand viewed as a (LEN+1)-bit two's-complement value.
  logic ax, bx, ext_eq, ext_gt;
  assign ax = A_SIGNED & A[LEN-1];
  assign bx = B_SIGNED & B[LEN-1];

  cmp_chunk #(.W(1)) u_ext (
    .a  (ax),
    .b  (bx),
    .eq (ext_eq),
    .gt (ext_gt)
  );

  // Current slice selected by a right shift, which stays in range for any idx.
  logic [CHUNK-1:0] a_c, b_c;
  logic             ch_eq, ch_gt;
  assign a_c = CHUNK'(a_q >> (int'(idx_q) * CHUNK));
  assign b_c = CHUNK'(b_q >> (int'(idx_q) * CHUNK));

  cmp_chunk #(.W(CHUNK)) u_chunk (
    .a  (a_c),
    .b  (b_c),
    .eq (ch_eq),
    .gt (ch_gt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = A;
          b_d   = B;
          cnt_d = '0;
          if (!ext_eq) begin
            // A set extension bit means that operand is negative, hence smaller.
            res_d   = ext_gt ? RES_LT : RES_GT;
            state_d = DONE;
          end else begin
            idx_d   = IW'(NCHUNK - 1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!ch_eq) begin
          res_d   = ch_gt ? RES_GT : RES_LT;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign EQ        = res_q[0];
  assign GT        = res_q[1];
  assign LT        = res_q[2];
  assign CNT       = cnt_q;

endmodule

// File: tb/tb_cmp_seq.sv
// tb_cmp_seq: directed + random checks of cmp_seq in two configurations
// (LEN=16/CHUNK=4 and LEN=8/CHUNK=8) against an arithmetic reference model.
module tb_cmp_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cur;          // 0: 16-bit instance, 1: 8-bit instance
  logic        in_valid, out_ready, as_i, bs_i;
  logic [15:0] a_in, b_in;

  logic       ir16, ov16, eq16, gt16, lt16;
  logic [2:0] cnt16;
  logic       ir8, ov8, eq8, gt8, lt8;
  logic [0:0] cnt8;

  cmp_seq #(.LEN(16), .CHUNK(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~cur), .in_ready(ir16),
    .A(a_in), .B(b_in), .A_SIGNED(as_i), .B_SIGNED(bs_i),
    .out_valid(ov16), .out_ready(out_ready & ~cur),
    .EQ(eq16), .GT(gt16), .LT(lt16), .CNT(cnt16)
  );

  cmp_seq #(.LEN(8), .CHUNK(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid & cur), .in_ready(ir8),
    .A(a_in[7:0]), .B(b_in[7:0]), .A_SIGNED(as_i), .B_SIGNED(bs_i),
    .out_valid(ov8), .out_ready(out_ready & cur),
    .EQ(eq8), .GT(gt8), .LT(lt8), .CNT(cnt8)
  );

  logic       o_ir, o_ov;
  logic [2:0] o_flags, o_cnt;
  assign o_ir    = cur ? ir8 : ir16;
  assign o_ov    = cur ? ov8 : ov16;
  assign o_flags = cur ? {lt8, gt8, eq8} : {lt16, gt16, eq16};
  assign o_cnt   = cur ? {2'b00, cnt8} : cnt16;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: true integer ordering of the two operands, and the number of
  // MSB-first chunks up to and including the first one that differs.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input bit as, input bit bs, input int len,
                                input int chunk, output logic [2:0] flags,
                                output int cnt);
    longint va, vb;
    logic [15:0] x;
    int p;
    bit ax, bx;
    ax = as & a[len-1];
    bx = bs & b[len-1];
    va = ax ? longint'(a) - (longint'(1) << len) : longint'(a);
    vb = bx ? longint'(b) - (longint'(1) << len) : longint'(b);
    flags = (va == vb) ? 3'b001 : (va > vb) ? 3'b010 : 3'b100;
    x = (a ^ b) & 16'((1 << len) - 1);
    if (ax != bx) cnt = 0;
    else if (x == 0) cnt = len / chunk;
    else begin
      p = 0;
      for (int i = 0; i < 16; i++) if (x[i]) p = i;
      cnt = (len - 1 - p) / chunk + 1;
    end
  endfunction

  task automatic txn(input logic [15:0] a, input logic [15:0] b,
                     input bit as, input bit bs, input string tag);
    logic [2:0] ef;
    int ec, lat, len, ch;
    len = cur ? 8 : 16;
    ch  = cur ? 8 : 4;
    if (cur) begin
      a = a & 16'h00FF;
      b = b & 16'h00FF;
    end
    model(a, b, as, bs, len, ch, ef, ec);
    @(negedge clk);
    a_in = a; b_in = b; as_i = as; bs_i = bs; in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(o_ir), 32'd1);
    @(negedge clk);
    // Scramble inputs after accept: the registered operands must be used.
    in_valid = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom);
    as_i = 1'($urandom); bs_i = 1'($urandom);
    lat = 1;
    while (!o_ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(ec + 1));
    chk({tag, ".flags"}, 32'(o_flags), 32'(ef));
    chk({tag, ".cnt"}, 32'(o_cnt), 32'(ec));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ov_after"}, 32'(o_ov), 32'd0);
    chk({tag, ".ir_after"}, 32'(o_ir), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ef;
    int ec, w;
    logic [15:0] ra, rb;

    cur = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; as_i = 1'b0; bs_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst.ir", 32'(o_ir), 32'd0);
    chk("rst.ov", 32'(o_ov), 32'd0);
    chk("rst.flags", 32'(o_flags), 32'd0);
    chk("rst.cnt", 32'(o_cnt), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("rel.ir", 32'(o_ir), 32'd1);

    // Directed cases, LEN=16 CHUNK=4
    txn(16'h1234, 16'h1234, 0, 0, "eq");
    txn(16'h8000, 16'h0001, 1, 1, "early_ss");
    txn(16'h8000, 16'h0001, 0, 0, "early_uu");
    txn(16'h1235, 16'h1234, 0, 0, "lsb_gt");
    txn(16'hFFFF, 16'hFFFF, 1, 0, "mix_su");
    txn(16'hFFFF, 16'hFFFF, 0, 1, "mix_us");
    txn(16'hFFFF, 16'hFFFF, 1, 1, "mix_ss");

    // Backpressure: result held, new operands dropped
    model(16'h0010, 16'h0020, 0, 0, 16, 4, ef, ec);
    @(negedge clk);
    a_in = 16'h0010; b_in = 16'h0020; as_i = 1'b0; bs_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 1;
    while (!o_ov && w < 20) begin @(negedge clk); w++; end
    chk("bp.latency", 32'(w), 32'(ec + 1));
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom);
      @(negedge clk);
      chk("bp.ov", 32'(o_ov), 32'd1);
      chk("bp.ir", 32'(o_ir), 32'd0);
      chk("bp.flags", 32'(o_flags), 32'(ef));
      chk("bp.cnt", 32'(o_cnt), 32'(ec));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.ir_after", 32'(o_ir), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.dropped", 32'(o_ov), 32'd0);
    end

    // Reset mid-operation
    @(negedge clk);
    a_in = 16'h1230; b_in = 16'h1234; as_i = 1'b0; bs_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.ov", 32'(o_ov), 32'd0);
    chk("abort.ir", 32'(o_ir), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort.ir_rel", 32'(o_ir), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort.no_ov", 32'(o_ov), 32'd0);
    end
    txn(16'h0001, 16'h0002, 0, 0, "post_rst");

    // Random, LEN=16
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (16'd1 << $urandom_range(0, 15));
      endcase
      txn(ra, rb, 1'($urandom), 1'($urandom), "rnd16");
    end

    // Degenerate LEN=8 CHUNK=8
    cur = 1'b1;
    txn(16'h007F, 16'h0080, 1, 1, "deg_ss");
    txn(16'h007F, 16'h0080, 0, 0, "deg_uu");
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = ($urandom_range(0, 2) == 0) ? ra : 16'($urandom_range(0, 255));
      txn(ra, rb, 1'($urandom), 1'($urandom), "rnd8");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmp_seq.md
# cmp_seq

Parametrised, chunk-serial magnitude comparator for wide operands. It evaluates equality and ordering one CHUNK-wide slice per cycle, starting from the MSB, and stops at the first differing slice. Each operand's signedness is selected per transaction, so one block covers signed, unsigned and both mixed comparisons. It sits where a flat single-cycle comparator would cost too many gates, and trades latency for area.

## Interface
- LEN, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 ≤ CHUNK ≤ LEN.
- NCHUNK, LEN/CHUNK, derived; not overridden.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands and modes presented.
- in_ready  out  1  block idle and able to accept.
- A  in  LEN  operand A.
- B  in  LEN  operand B.
- A_SIGNED  in  1  treat A as two's complement.
- B_SIGNED  in  1  treat B as two's complement.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- EQ  out  1  A == B.
- GT  out  1  A > B.
- LT  out  1  A < B.
- CNT  out  $clog2(NCHUNK+1)  number of chunks examined before the decision.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE, zeroes the result registers and clears CNT.
- in_ready = (state==IDLE) & !rst. out_valid = (state==DONE).
- **Accept** happens on in_valid & in_ready.
  - A, B, A_SIGNED and B_SIGNED are registered. Later changes on the inputs are ignored.
  - Extension bits are computed as a_x = A_SIGNED & A[LEN-1] and b_x = B_SIGNED & B[LEN-1]. Conceptually each operand becomes a (LEN+1)-bit two's-complement value.
  - If a_x ≠ b_x, the result is decided immediately: a_x=1 gives LT, otherwise GT. CNT=0 and the next state is DONE.
  - Otherwise the next state is RUN with the chunk index idx = NCHUNK-1.
- **RUN**, once per cycle:
  - Compare A[idx*CHUNK +: CHUNK] against B[idx*CHUNK +: CHUNK] unsigned. CNT increments.
  - A differing chunk decides the result: GT if the A chunk is larger, else LT. Next state is DONE.
  - Equal chunks with idx==0 give EQ, and the next state is DONE.
  - Equal chunks with idx>0 decrement idx and stay in RUN.
- **DONE**:
  - EQ, GT, LT and CNT are held stable. Exactly one of EQ/GT/LT is 1.
  - On out_ready the block moves to IDLE.
  - In IDLE the flags keep their last values, but they are only meaningful while out_valid is high.
- Width rule: the chunk comparator works on CHUNK unsigned bits. Signedness affects only the extension-bit step.

## Timing
- Cycle 0 is the accept cycle.
- Decision in the extension step: out_valid is high in cycle 1.
- Decision at chunk j (1 = MSB chunk): out_valid is high in cycle j+1 and CNT=j.
- Full equality: out_valid is high in cycle NCHUNK+1 and CNT=NCHUNK.
- Result handshake completes in the cycle where out_valid & out_ready are both high. The state is IDLE the next cycle, and in_ready rises then. There is no back-to-back accept in the same cycle as result handoff.
- Throughput is at most one transaction per (latency+1) cycles.
- out_ready held low: DONE and all outputs are stable indefinitely, and in_valid is ignored.
- in_valid while not IDLE: ignored. Nothing is queued.
- Asserting rst mid-RUN or in DONE aborts the transaction at once. The block is in IDLE with out_valid=0 immediately, and the aborted result is never presented.
- in_ready is 0 while rst is high and 1 from the first cycle after release.

## Structure
- cmp_pkg holds:
  - the state enum: IDLE, RUN, DONE.
  - the result encoding localparams: RES_EQ, RES_GT, RES_LT.
- Sub-module cmp_chunk: combinational, parameter W. It takes inputs a and b [W-1:0] and produces eq and gt. It is instantiated once for the chunk slice and once with W=1 for the extension bits.
- The top level is cmp_seq, with a registered index, counter, operands and result.

## Test plan
- Equality, LEN=16, CHUNK=4: A=B=0x1234, both unsigned. Expect EQ=1, GT=LT=0, CNT=4, out_valid in cycle 5.
- Early exit: A=0x8000, B=0x0001.
  - Both signed: LT, CNT=0, cycle 1.
  - Both unsigned: GT, CNT=1, cycle 2.
  - A=0x1235, B=0x1234 unsigned: GT, CNT=4.
- Mixed signedness: A=0xFFFF, B=0xFFFF.
  - A signed, B unsigned: LT, CNT=0.
  - A unsigned, B signed: GT, CNT=0.
  - Both signed: EQ, CNT=4.
- Backpressure: hold out_ready low for 3 cycles after out_valid rises, and pulse in_valid with new operands. Outputs stay unchanged, in_ready=0 throughout, the new operands are dropped, and in_ready=1 the cycle after out_ready.
- Reset mid-operation: A=0x1230, B=0x1234 unsigned, rst asserted in cycle 2. out_valid never rises, and after release in_ready=1. A following transaction with A=0x0001, B=0x0002 returns LT, CNT=4.
- Degenerate parameters:
  - LEN=8, CHUNK=8, A=0x7F, B=0x80, both signed: GT, CNT=0.
  - Same operands, unsigned: LT, CNT=1, out_valid in cycle 2.
